// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: load/start/router-side signals of the packet transmitter.
// ROUTER_TX_PARITY_INJ_EN adds corrupt_parity.
interface router_pkt_tx_if;
   logic       ld_en;
   logic [7:0] ld_data;
   logic       start;
   logic [1:0] dest_addr;
   logic       busy;
`ifdef ROUTER_TX_PARITY_INJ_EN
   logic       corrupt_parity;
`endif
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_active;
   logic       done;
   logic       start_err;
   logic       load_err;
   logic [5:0] buf_count;
   modport master (
      input  ld_en, ld_data, start, dest_addr, busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
      input  corrupt_parity,
`endif
      output pkt_valid, data_out, tx_active, done, start_err, load_err, buf_count
   );
   modport slave (
      output ld_en, ld_data, start, dest_addr, busy,
`ifdef ROUTER_TX_PARITY_INJ_EN
      output corrupt_parity,
`endif
      input  pkt_valid, data_out, tx_active, done, start_err, load_err, buf_count
   );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload and frames it as header, payload, parity toward the router.
// ROUTER_TX_PARITY_INJ_EN adds corrupt_parity to flip bit 0 of the emitted parity byte.
module router_pkt_tx #(
   parameter int MAX_LEN    = 63,
   parameter int GAP_CYCLES = 2
) (
   input logic clock,
   input logic resetn,
   router_pkt_tx_if.master tx
);
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
   state_t state, state_nx;
   logic [7:0] mem [0:63];
   logic [5:0] count, count_nx, len, len_nx, ptr, ptr_nx;
   logic [7:0] par, par_nx, dout, dout_nx, gap, gap_nx;
   logic valid, valid_nx, done_q, done_nx, serr, serr_nx, lerr, lerr_nx;
   logic start_ok, load_ok, last, inj;
`ifdef ROUTER_TX_PARITY_INJ_EN
   assign inj = tx.corrupt_parity;
`else
   assign inj = 1'b0;
`endif
   assign start_ok = tx.start && count != 6'd0 && tx.dest_addr != 2'd3;
   assign load_ok  = state == IDLE && tx.ld_en && !tx.start && count < 6'(MAX_LEN);
   assign last     = ptr == len;
   assign tx.pkt_valid = valid;
   assign tx.data_out  = dout;
   assign tx.tx_active = state != IDLE;
   assign tx.done      = done_q;
   assign tx.start_err = serr;
   assign tx.load_err  = lerr;
   assign tx.buf_count = count;
   always_ff @(posedge clock)
      state <= !resetn ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_ok ? HEADER : IDLE;
         HEADER:  state_nx = !tx.busy ? PAYLOAD : HEADER;
         PAYLOAD: state_nx = (!tx.busy && last) ? PARITY : PAYLOAD;
         PARITY:  state_nx = tx.busy ? PARITY : (GAP_CYCLES == 0 ? IDLE : GAP);
         GAP:     state_nx = gap == GAP_LAST ? IDLE : GAP;
         default: state_nx = IDLE;
      endcase
   end
   // Next values of every registered output and datapath register.
   always_comb begin
      valid_nx = valid;
      dout_nx  = dout;
      par_nx   = par;
      ptr_nx   = ptr;
      len_nx   = len;
      count_nx = count + {5'd0, load_ok};
      gap_nx   = 8'd0;
      done_nx  = 1'b0;
      serr_nx  = state == IDLE && tx.start && !start_ok;
      lerr_nx  = tx.ld_en && !load_ok;
      case (state)
         IDLE: if (start_ok) begin
            valid_nx = 1'b1;
            dout_nx  = {count, tx.dest_addr};
            par_nx   = 8'd0;
            len_nx   = count;
         end
         HEADER: if (!tx.busy) begin
            par_nx  = par ^ dout;
            dout_nx = mem[0];
            ptr_nx  = 6'd1;
         end
         PAYLOAD: if (!tx.busy) begin
            par_nx   = par ^ dout;
            dout_nx  = last ? (par ^ dout ^ {7'd0, inj}) : mem[ptr];
            ptr_nx   = last ? ptr : ptr + 6'd1;
            valid_nx = !last;
         end
         PARITY: if (!tx.busy) begin
            dout_nx  = 8'd0;
            count_nx = 6'd0;
            ptr_nx   = 6'd0;
            done_nx  = GAP_CYCLES == 0;
         end
         GAP: begin
            gap_nx  = gap + 8'd1;
            done_nx = gap == GAP_LAST;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         valid  <= 1'b0;
         dout   <= 8'd0;
         par    <= 8'd0;
         ptr    <= 6'd0;
         len    <= 6'd0;
         count  <= 6'd0;
         gap    <= 8'd0;
         done_q <= 1'b0;
         serr   <= 1'b0;
         lerr   <= 1'b0;
      end else begin
         valid  <= valid_nx;
         dout   <= dout_nx;
         par    <= par_nx;
         ptr    <= ptr_nx;
         len    <= len_nx;
         count  <= count_nx;
         gap    <= gap_nx;
         done_q <= done_nx;
         serr   <= serr_nx;
         lerr   <= lerr_nx;
      end
   end
   always_ff @(posedge clock)
      if (resetn && load_ok) mem[count] <= tx.ld_data;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: random packets against a frame-level reference model of router_pkt_tx.
// Build with ROUTER_TX_PARITY_INJ_EN to also exercise parity corruption.
module tb_router_pkt_tx;
   localparam int MAX_LEN = 63;
   localparam int GAP = 2;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] q [$];
   router_pkt_tx_if t ();
   router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (.clock(clock), .resetn(resetn), .tx(t.master));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic load(input logic [7:0] d);
      logic err;
      t.ld_en = 1'b1;
      t.ld_data = d;
      step();
      t.ld_en = 1'b0;
      err = q.size() >= MAX_LEN;
      if (!err) q.push_back(d);
      chk("load_err", 8'(t.load_err), 8'(err));
      chk("load_cnt", 8'(t.buf_count), 8'(q.size()));
   endtask
   task automatic send(input logic [1:0] dest, input int busy_pct, input int hold,
                       input logic corrupt, input logic ld_with_start);
      logic [7:0] frame [$];
      logic [7:0] p;
      logic ld_prev, c;
      int idx, held;
      c = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
      c = corrupt;
      t.corrupt_parity = corrupt;
`endif
      frame = {};
      frame.push_back({6'(q.size()), dest});
      foreach (q[i]) frame.push_back(q[i]);
      p = 8'd0;
      foreach (frame[i]) p ^= frame[i];
      frame.push_back(p ^ {7'd0, c});
      t.dest_addr = dest;
      t.start = 1'b1;
      t.ld_en = ld_with_start;
      t.ld_data = 8'($urandom);
      step();
      t.start = 1'b0;
      t.ld_en = 1'b0;
      idx = 0;
      held = 0;
      ld_prev = ld_with_start;
      while (idx < frame.size()) begin
         chk("data", t.data_out, frame[idx]);
         chk("valid", 8'(t.pkt_valid), 8'(idx < frame.size() - 1));
         chk("active", 8'(t.tx_active), 8'd1);
         chk("tx_lerr", 8'(t.load_err), 8'(ld_prev));
         chk("tx_cnt", 8'(t.buf_count), 8'(q.size()));
         if (idx == 0 && held < hold) begin
            t.busy = 1'b1;
            held++;
         end else t.busy = $urandom_range(99) < busy_pct;
         t.ld_en = $urandom_range(3) == 0;
         t.ld_data = 8'($urandom);
         t.start = 1'($urandom);
         t.dest_addr = 2'($urandom);
         ld_prev = t.ld_en;
         step();
         if (!t.busy) idx++;
      end
      t.busy = 1'b0;
      t.ld_en = 1'b0;
      t.start = 1'b0;
      q = {};
      for (int g = 0; g < GAP; g++) begin
         chk("gap_lerr", 8'(t.load_err), 8'(ld_prev));
         ld_prev = 1'b0;
         chk("gap_valid", 8'(t.pkt_valid), 8'd0);
         chk("gap_data", t.data_out, 8'd0);
         chk("gap_done", 8'(t.done), 8'd0);
         chk("gap_active", 8'(t.tx_active), 8'd1);
         chk("gap_cnt", 8'(t.buf_count), 8'd0);
         step();
      end
      chk("done", 8'(t.done), 8'd1);
      chk("done_active", 8'(t.tx_active), 8'd0);
      chk("done_cnt", 8'(t.buf_count), 8'd0);
      chk("done_valid", 8'(t.pkt_valid), 8'd0);
      step();
      chk("done_pulse", 8'(t.done), 8'd0);
`ifdef ROUTER_TX_PARITY_INJ_EN
      t.corrupt_parity = 1'b0;
`endif
   endtask
   initial begin
      t.ld_en = 1'b0;
      t.ld_data = 8'd0;
      t.start = 1'b0;
      t.dest_addr = 2'd0;
      t.busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
      t.corrupt_parity = 1'b0;
`endif
      step();
      step();
      chk("rst_valid", 8'(t.pkt_valid), 8'd0);
      chk("rst_data", t.data_out, 8'd0);
      chk("rst_active", 8'(t.tx_active), 8'd0);
      chk("rst_done", 8'(t.done), 8'd0);
      chk("rst_serr", 8'(t.start_err), 8'd0);
      chk("rst_lerr", 8'(t.load_err), 8'd0);
      chk("rst_cnt", 8'(t.buf_count), 8'd0);
      resetn = 1'b1;
      step();
      load(8'h11); load(8'h22); load(8'h33);
      send(2'd1, 0, 0, 1'b0, 1'b0);
      load(8'h11); load(8'h22); load(8'h33);
      send(2'd1, 0, 3, 1'b0, 1'b0);
      t.start = 1'b1;
      t.dest_addr = 2'd0;
      step();
      t.start = 1'b0;
      chk("serr_empty", 8'(t.start_err), 8'd1);
      chk("serr_valid", 8'(t.pkt_valid), 8'd0);
      chk("serr_active", 8'(t.tx_active), 8'd0);
      step();
      chk("serr_pulse", 8'(t.start_err), 8'd0);
      load(8'h5A); load(8'h3C);
      t.start = 1'b1;
      t.dest_addr = 2'd3;
      step();
      t.start = 1'b0;
      chk("serr_dest3", 8'(t.start_err), 8'd1);
      chk("serr3_valid", 8'(t.pkt_valid), 8'd0);
      chk("serr3_active", 8'(t.tx_active), 8'd0);
      chk("serr3_cnt", 8'(t.buf_count), 8'd2);
      send(2'd0, 20, 0, 1'b0, 1'b1);
      for (int i = 0; i < MAX_LEN + 1; i++) load(8'hA5);
      send(2'd2, 25, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) load(8'($urandom));
      t.start = 1'b1;
      t.dest_addr = 2'd0;
      step();
      t.start = 1'b0;
      step();
      step();
      resetn = 1'b0;
      step();
      chk("mid_rst_valid", 8'(t.pkt_valid), 8'd0);
      chk("mid_rst_data", t.data_out, 8'd0);
      chk("mid_rst_active", 8'(t.tx_active), 8'd0);
      chk("mid_rst_cnt", 8'(t.buf_count), 8'd0);
      chk("mid_rst_done", 8'(t.done), 8'd0);
      resetn = 1'b1;
      q = {};
      step();
      chk("post_rst_active", 8'(t.tx_active), 8'd0);
      for (int k = 0; k < 8; k++) begin
         int n;
         n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++) load(8'($urandom));
         send(2'($urandom_range(2)), 30, 0, 1'b0, 1'($urandom));
      end
`ifdef ROUTER_TX_PARITY_INJ_EN
      load(8'h11); load(8'h22); load(8'h33);
      send(2'd1, 0, 0, 1'b1, 1'b0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
